ssp_reg_access_arbiter: RTL
===========================

// Module: ssp_reg_access_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer that shares the single SSP register port of ssp_uart among
//  NUM_REQ requesters (host CPU, DMA, self-test). Each requester posts one register access
//  (addr/WnR/data) with a req/ack handshake. The block drives SSEL/RA/WnR/DI/EOC with fixed
//  timing and captures SSP_DO. It sits between the system bus adapters and the ssp_uart SSP port.
// PARAMETERS
//  NUM_REQ  2  number of requesters (2..4)
//  RD_LAT   2  Clk cycles after EOC strobe before SSP_DO is valid / write has latched (>=1)
// PORTS
//  Clk        in   1            system clock, all logic on posedge
//  Rst        in   1            synchronous, active-high reset
//  req        in   NUM_REQ      per-requester access request, held until matching ack
//  req_ra     in   3*NUM_REQ    register address per requester (0 UCR,1 USR,2 RDR,3 TDR,4 SPR)
//  req_wnr    in   NUM_REQ      1 = write, 0 = read
//  req_wdata  in   12*NUM_REQ   write data per requester
//  ack        out  NUM_REQ      one-cycle done pulse to the granted requester
//  rsp_rdata  out  12           read data, valid in the ack cycle
//  rsp_err    out  1            error flag, valid in the ack cycle
//  busy       out  1            high in every state except IDLE
//  SSP_SSEL   out  1            slave select to ssp_uart
//  SSP_RA     out  3            register address
//  SSP_WnR    out  1            write/not-read
//  SSP_EOC    out  1            end-of-cycle strobe
//  SSP_DI     out  12           write data
//  SSP_DO     in   12           read data from ssp_uart
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, RR pointer=0. Rst mid-transaction aborts it: no ack is issued.
//   The requester must re-request.
//  FSM: IDLE -> SETUP -> STROBE -> WAIT(RD_LAT cycles) -> DONE -> IDLE.
//  IDLE: if |req, grant the first asserted index at or after ptr (wrapping). Latch winner idx, ra,
//   wnr and wdata. Set ptr = (winner+1) mod NUM_REQ. Go to SETUP, or to DONE if ra>4.
//  SETUP: SSEL=1; RA/WnR/DI driven from the latched values; EOC=0.
//  STROBE: as SETUP with EOC=1 for exactly one cycle.
//  WAIT: SSEL=1, EOC=0. A down-counter runs RD_LAT cycles. On the last cycle, a read captures
//   SSP_DO into the rdata register.
//  DONE: SSEL=0 and all SSP_* outputs = 0. ack[winner]=1 for one cycle. rsp_rdata = captured
//   value for reads, 0 for writes. rsp_err=1 only for an invalid ra.
//  Latency (req high at IDLE edge k): ack high after edge k+3+RD_LAT (5 cycles at default).
//   Invalid ra: ack after edge k+1, SSP_SSEL never asserted.
//  Outputs are registered and the SSP_* outputs are stable for the whole SETUP..WAIT window.
//   Latched request fields are immune to req/data changes after grant.
//  A requester dropping req after grant does not cancel the access; ack is still pulsed.
//  ack is asserted in DONE and the FSM returns to IDLE on the next edge, so a requester can
//   drop or re-raise req in the cycle after ack.
//  Minimum spacing between transactions is 1 IDLE cycle. ack and SSP_SSEL are never high together.
// CONFIGURATION
//  SSP_WR_VERIFY_EN defined: a write to UCR (0) or SPR (4) appends a readback before DONE:
//   SETUP/STROBE/WAIT repeated with WnR=0 and the same RA.
//   SSP_DO != wdata -> rsp_err=1, and rsp_rdata = the value read back.
//   Adds 2+RD_LAT cycles to the write latency.
//   Writes to TDR and other addresses are not verified.
//  Not defined: no readback; write latency as above; rsp_err is set only by an invalid ra.
// TESTING
//  1 Reset held 3 cycles -> all outputs 0, busy=0; Rst released -> no SSP activity without req.
//  2 req[0] write UCR 12'hDED -> SSEL high from cycle 1, single EOC pulse in cycle 2,
//    ack[0] in cycle 5; then req[0] read UCR -> rsp_rdata=12'hDED, rsp_err=0.
//  3 req=2'b11 held continuously, writes to SPR (12'h111 / 12'h222) -> grants alternate
//    0,1,0,1; DUT SPR readback matches the last grant.
//  4 req[1] ra=3'b101 -> ack[1] one cycle after request, rsp_err=1, SSP_SSEL stays 0.
//  5 Rst pulsed during WAIT -> next cycle SSEL=0 and busy=0, no ack; re-request completes normally.
//  6 With SSP_WR_VERIFY_EN, SSP_DO forced to 12'h000 during readback of a UCR 12'hABC write ->
//    ack in cycle 9, rsp_err=1, rsp_rdata=0. Without the macro -> ack in cycle 5, rsp_err=0.

Source files
------------

// File: rtl/ssp_reg_access_arbiter.sv
// Round-robin arbiter/sequencer sharing the ssp_uart SSP register port among NUM_REQ requesters.
// Optional write readback verification of UCR/SPR is enabled by defining SSP_WR_VERIFY_EN.
module ssp_reg_access_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [3*NUM_REQ-1:0]  req_ra,
  input  logic [NUM_REQ-1:0]    req_wnr,
  input  logic [12*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    ack,
  output logic [11:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  SSP_SSEL,
  output logic [2:0]            SSP_RA,
  output logic                  SSP_WnR,
  output logic                  SSP_EOC,
  output logic [11:0]           SSP_DI,
  input  logic [11:0]           SSP_DO
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [2:0]        ra_q, ra_d;
  logic              wnr_q, wnr_d;
  logic [11:0]       wdata_q, wdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [11:0]       cap_q, cap_d;
  logic              err_q, err_d;
  logic              rb_q, rb_d;

  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [11:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               ssel_q, ssel_d;
  logic [2:0]         ssp_ra_q, ssp_ra_d;
  logic               ssp_wnr_q, ssp_wnr_d;
  logic               ssp_eoc_q, ssp_eoc_d;
  logic [11:0]        ssp_di_q, ssp_di_d;

  logic              gnt_found;
  logic [IdxW-1:0]   gnt_idx;
  logic [2:0]        sel_ra;
  logic              sel_wnr;
  logic [11:0]       sel_wdata;

  // Descending scans leave the lowest index; indices at/after ptr override the wrapped group.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
      if (req[j] && (IdxW'(j) < ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = IdxW'(j);
      end
    end
    for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
      if (req[j] && (IdxW'(j) >= ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = IdxW'(j);
      end
    end
  end

  always_comb begin
    sel_ra    = '0;
    sel_wnr   = 1'b0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IdxW'(i)) begin
        sel_ra    = req_ra[3*i +: 3];
        sel_wnr   = req_wnr[i];
        sel_wdata = req_wdata[12*i +: 12];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    ra_d    = ra_q;
    wnr_d   = wnr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    err_d   = err_q;
    rb_d    = rb_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          idx_d   = gnt_idx;
          ra_d    = sel_ra;
          wnr_d   = sel_wnr;
          wdata_d = sel_wdata;
          ptr_d   = (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          cap_d   = '0;
          rb_d    = 1'b0;
          err_d   = (sel_ra > 3'd4);
          state_d = (sel_ra > 3'd4) ? StDone : StSetup;
        end
      end
      StSetup:  state_d = StStrobe;
      StStrobe: begin
        state_d = StWait;
        cnt_d   = CntW'(RD_LAT - 1);
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          if (!wnr_q || rb_q) cap_d = SSP_DO;
`ifdef SSP_WR_VERIFY_EN
          if (rb_q) begin
            err_d = (SSP_DO != wdata_q);
          end else if (wnr_q && (ra_q == 3'd0 || ra_q == 3'd4)) begin
            rb_d    = 1'b1;
            state_d = StSetup;
          end
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from next-state so they line up with the state they belong to.
  always_comb begin
    ssel_d      = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StWait);
    ssp_ra_d    = ssel_d ? ra_d : '0;
    ssp_wnr_d   = ssel_d & wnr_d & ~rb_d;
    ssp_di_d    = ssel_d ? wdata_d : '0;
    ssp_eoc_d   = (state_d == StStrobe);
    ack_d       = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    if (state_d == StDone) begin
      ack_d[idx_d] = 1'b1;
      rsp_err_d    = err_d;
      rsp_rdata_d  = (wnr_d && !err_d) ? '0 : cap_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      idx_q       <= '0;
      ra_q        <= '0;
      wnr_q       <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cap_q       <= '0;
      err_q       <= 1'b0;
      rb_q        <= 1'b0;
      ack_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      ssel_q      <= 1'b0;
      ssp_ra_q    <= '0;
      ssp_wnr_q   <= 1'b0;
      ssp_eoc_q   <= 1'b0;
      ssp_di_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      ra_q        <= ra_d;
      wnr_q       <= wnr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      err_q       <= err_d;
      rb_q        <= rb_d;
      ack_q       <= ack_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      ssel_q      <= ssel_d;
      ssp_ra_q    <= ssp_ra_d;
      ssp_wnr_q   <= ssp_wnr_d;
      ssp_eoc_q   <= ssp_eoc_d;
      ssp_di_q    <= ssp_di_d;
    end
  end

  assign ack       = ack_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != StIdle);
  assign SSP_SSEL  = ssel_q;
  assign SSP_RA    = ssp_ra_q;
  assign SSP_WnR   = ssp_wnr_q;
  assign SSP_EOC   = ssp_eoc_q;
  assign SSP_DI    = ssp_di_q;

endmodule
